// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the serial comparator controller.
package serial_cmp_pkg;

    localparam int CHUNK_W = 3;

    // Seed for the cascade chain: "equal so far", ordered {l,e,g}.
    localparam logic [2:0] CASC_EQ = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_comparator_ctrl_if.sv
// Start/done request bus between a wide-compare client and the serial comparator.
interface serial_comparator_ctrl_if #(
    parameter int WIDTH = 12
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             lt;
    logic             eq;
    logic             gt;

    modport master (
        output start, a_in, b_in,
        input  busy, done, lt, eq, gt
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, lt, eq, gt
    );
endinterface

// File: rtl/comparator3.sv
// Cascadable 3-bit unsigned magnitude comparator; purely combinational.
module comparator3 (
    input  logic [2:0] a_i,
    input  logic [2:0] b_i,
    input  logic       l_i,
    input  logic       e_i,
    input  logic       g_i,
    output logic       lt_o,
    output logic       eq_o,
    output logic       gt_o
);
    // A local difference dominates; only an equal chunk passes the lower verdict through.
    always_comb begin
        lt_o = 1'b0;
        eq_o = 1'b0;
        gt_o = 1'b0;
        if (a_i > b_i) begin
            gt_o = 1'b1;
        end else if (a_i < b_i) begin
            lt_o = 1'b1;
        end else begin
            lt_o = l_i;
            eq_o = e_i;
            gt_o = g_i;
        end
    end
endmodule

// File: rtl/serial_comparator_ctrl.sv
// Compares two WIDTH-bit unsigned operands LSB-chunk-first through one comparator3.
// Done pulses CHUNKS+1 cycles after an accepted start; start during RUN is dropped.
module serial_comparator_ctrl
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_comparator_ctrl_if.slave  bus
);
    localparam int CHUNKS = WIDTH / CHUNK_W;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    if (WIDTH < CHUNK_W || (WIDTH % CHUNK_W) != 0) begin : g_width_bad
        $error("serial_comparator_ctrl: WIDTH must be a positive multiple of 3");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       casc_q, casc_d;
    logic [2:0]       res_q, res_d;

    logic [CHUNK_W-1:0] a_chunk, b_chunk;
    logic               cmp_lt, cmp_eq, cmp_gt;

    assign a_chunk = a_q[CHUNK_W*count_q +: CHUNK_W];
    assign b_chunk = b_q[CHUNK_W*count_q +: CHUNK_W];

    comparator3 u_cmp (
        .a_i  (a_chunk),
        .b_i  (b_chunk),
        .l_i  (casc_q[2]),
        .e_i  (casc_q[1]),
        .g_i  (casc_q[0]),
        .lt_o (cmp_lt),
        .eq_o (cmp_eq),
        .gt_o (cmp_gt)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        casc_d  = casc_q;
        res_d   = res_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    count_d = '0;
                    casc_d  = CASC_EQ;
                end
            end
            RUN: begin
                casc_d  = {cmp_lt, cmp_eq, cmp_gt};
                count_d = count_q + CW'(1);
                if (count_q == CW'(CHUNKS - 1)) begin
                    // Only the MSB pass publishes; earlier passes stay internal.
                    res_d   = {cmp_lt, cmp_eq, cmp_gt};
                    count_d = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            casc_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            casc_q  <= casc_d;
            res_q   <= res_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.lt   = res_q[2];
    assign bus.eq   = res_q[1];
    assign bus.gt   = res_q[0];
endmodule
